// File: rtl/time_digit_loader_pkg.sv
// rtl/time_digit_loader_pkg.sv - shared timer constants, state enum and x10 helper
package time_digit_loader_pkg;

  localparam int BCD_W = 4;
  localparam int TIME_W = 6;
  localparam int ACC_W = 7;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    S_TENS,
    S_ONES,
    M_TENS,
    M_ONES,
    COMMIT,
    FAIL
  } state_t;

  // digit * 10 as (d << 3) + (d << 1)
  function automatic logic [ACC_W-1:0] times_ten(input logic [BCD_W-1:0] d);
    logic [ACC_W-1:0] w;
    w = {{(ACC_W-BCD_W){1'b0}}, d};
    return (w << 3) + (w << 1);
  endfunction

endpackage

// File: rtl/time_digit_loader.sv
// rtl/time_digit_loader.sv - range-checked sequential BCD mm:ss to binary preset loader
module time_digit_loader
  import time_digit_loader_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BCD_W-1:0]  ones,
  input  logic [BCD_W-1:0]  tens,
  input  logic [BCD_W-1:0]  hundreds,
  input  logic [BCD_W-1:0]  thousands,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TIME_W-1:0] seconds,
  output logic [TIME_W-1:0] minutes
);

  localparam logic [BCD_W-1:0] MIN_TENS_LIM = BCD_W'(MIN_TENS_MAX);

  state_t state, state_next;
  logic [BCD_W-1:0] ones_q, tens_q, hundreds_q, thousands_q;
  logic [ACC_W-1:0] acc, sec_stage, min_stage, min_sum;
  logic illegal;
  logic unused_stage;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign illegal = (ones_q > BCD_MAX) || (tens_q > SEC_TENS_MAX) ||
                   (hundreds_q > BCD_MAX) || (thousands_q > MIN_TENS_LIM);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = illegal ? FAIL : S_TENS;
      S_TENS:  state_next = S_ONES;
      S_ONES:  state_next = M_TENS;
      M_TENS:  state_next = M_ONES;
      M_ONES:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      FAIL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // minutes is committed on the same edge that finishes its sum, so it bypasses min_stage
  assign min_sum = acc + {{(ACC_W-BCD_W){1'b0}}, hundreds_q};
  assign unused_stage = ^{sec_stage[ACC_W-1], min_stage};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_q      <= '0;
      tens_q      <= '0;
      hundreds_q  <= '0;
      thousands_q <= '0;
      acc         <= '0;
      sec_stage   <= '0;
      min_stage   <= '0;
      seconds     <= '0;
      minutes     <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= (state_next == COMMIT) || (state_next == FAIL);
      error <= (state_next == FAIL);
      case (state)
        IDLE: if (start) begin
          ones_q      <= ones;
          tens_q      <= tens;
          hundreds_q  <= hundreds;
          thousands_q <= thousands;
        end
        S_TENS: acc <= times_ten(tens_q);
        S_ONES: sec_stage <= acc + {{(ACC_W-BCD_W){1'b0}}, ones_q};
        M_TENS: acc <= times_ten(thousands_q);
        M_ONES: begin
          min_stage <= min_sum;
          seconds   <= sec_stage[TIME_W-1:0];
          minutes   <= min_sum[TIME_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/time_digit_loader.md
# time_digit_loader

Sequential BCD-to-binary loader for the timer's preset path; the counterpart of the binary-to-digit splitter that drives the display. It takes four BCD digits (mm:ss) from the digit-entry logic on a start strobe and range-checks them. It then converts them to 6-bit binary `seconds`/`minutes` through a multi-cycle shift-add state machine and presents both values atomically with a one-cycle `done` pulse, so the seconds/minutes counters can be preloaded.

## Interface
- `MIN_TENS_MAX`, default 5: largest legal minutes-tens digit; legal range 0..5, so `minutes` never exceeds 59.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `ones`  in  4  seconds units digit, BCD.
- `tens`  in  4  seconds tens digit, BCD.
- `hundreds`  in  4  minutes units digit, BCD.
- `thousands`  in  4  minutes tens digit, BCD.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  registered one-cycle completion pulse.
- `error`  out  1  registered one-cycle pulse, coincident with `done`, on rejected input.
- `seconds`  out  6  binary seconds, 0..59.
- `minutes`  out  6  binary minutes, 0..10*MIN_TENS_MAX+9.

## Operation
- States: IDLE, CHECK, S_TENS, S_ONES, M_TENS, M_ONES, COMMIT, FAIL.
- **IDLE:**
  - When `start`=1, capture all four digits into internal registers and go to CHECK.
  - Input changes after the capture edge have no effect on the result.
- **CHECK:** the request is illegal if any of these hold:
  - any digit > 9;
  - `tens` > 5;
  - `hundreds` > 9;
  - `thousands` > MIN_TENS_MAX.
  - Illegal goes to FAIL; legal goes to S_TENS.
- **Conversion, one step per cycle:**
  - S_TENS: `acc` = tens×10, computed as (t<<3)+(t<<1).
  - S_ONES: `sec_stage` = `acc` + ones.
  - M_TENS: `acc` = thousands×10.
  - M_ONES: `min_stage` = `acc` + hundreds.
  - `acc` and the stage registers are 7 bits wide. Results are at most 59, so they are truncated to 6 bits losslessly.
- **COMMIT:**
  - On entry, `seconds` and `minutes` are loaded from the stage registers on the same edge that raises `done`.
  - Returns to IDLE after one cycle.
- **FAIL:**
  - On entry, `done`=1 and `error`=1 for one cycle.
  - `seconds` and `minutes` hold their previous values.
  - Returns to IDLE.
- `start` in any state other than IDLE is ignored; it is not queued.
- **Reset:** asynchronous, effective in any state, including mid-conversion.
  - State goes to IDLE.
  - `busy`, `done`, `error`, `seconds`, `minutes`, `acc` and the stage registers all clear to 0.
  - A partially converted request is discarded.

## Timing
- Edge E0 samples `start`; the state sequence is CHECK at E1, S_TENS at E2, S_ONES at E3, M_TENS at E4, M_ONES at E5, COMMIT at E6.
- Success: `done` and the new `seconds`/`minutes` become visible after E5 and `done` falls at E6. Latency is 6 edges from the sampling edge.
- Failure: `done` and `error` become visible after E1 and fall at E2. Latency is 2 edges.
- `busy` rises after E0 and falls when the state returns to IDLE.
- A new `start` can be accepted on the edge at which the state returns to IDLE. With `start` held high, requests are accepted every 7 edges on success and every 3 edges on failure.
- `done` is never asserted for two consecutive cycles.

## Structure
- A shared timer package holds:
  - the BCD digit width (4);
  - `BCD_MAX` = 9;
  - `SEC_TENS_MAX` = 5;
  - the time field width (6);
  - the state enum.
  - The display digit splitter uses the same package.
- No sub-module: the ×10 shift-add and the range compare are inline. The block is a single FSM with a datapath.

## Test plan
- Digits 9,5,9,5 (ones,tens,hundreds,thousands) with a `start` pulse -> `seconds`=59, `minutes`=59, `done` 6 edges after start, `error`=0, `busy` high for 6 cycles.
- Digits 3,4,2,1, then inputs changed to 0,0,0,0 one cycle after start -> `seconds`=43, `minutes`=12. A second `start` pulse during `busy` is ignored: exactly one `done`.
- Preload to 59/59, then request `tens`=6 -> `done`+`error` 2 edges after start, outputs stay 59/59. Repeat with `ones`=4'hA; the same response is required.
- MIN_TENS_MAX=2: `thousands`=3 -> error pulse. `thousands`=2, `hundreds`=9 -> `minutes`=29.
- Digits 0,0,0,0 after a 59/59 load -> `seconds`=0, `minutes`=0, `error`=0.
- `start` held high continuously with legal digits -> `done` pulses every 7 cycles. `reset` asserted mid-conversion in S_ONES -> all outputs 0 immediately (asynchronous), state IDLE, no `done` afterwards.
